// File: rtl/pulpino_mem_banked.sv
// Banked core-side SRAM interface: one req/gnt/rvalid port fanned out to NUM_BANKS
// macros, each with its own ON/SLEEP/WAKE power-gating state machine.
module pulpino_mem_banked #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 13,
  parameter int NUM_BANKS   = 4,
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 testmode_i,
  input  logic [NUM_BANKS-1:0]                 sleep_en_i,
  input  logic                                 req_i,
  input  logic [ADDR_WIDTH-1:0]                addr_i,
  input  logic                                 we_i,
  input  logic [DATA_WIDTH/8-1:0]              be_i,
  input  logic [DATA_WIDTH-1:0]                wdata_i,
  output logic                                 gnt_o,
  output logic                                 rvalid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic [NUM_BANKS-1:0]                 bank_en_o,
  output logic [ADDR_WIDTH-$clog2(NUM_BANKS)-1:0] bank_addr_o,
  output logic                                 bank_we_o,
  output logic [DATA_WIDTH/8-1:0]              bank_be_o,
  output logic [DATA_WIDTH-1:0]                bank_wdata_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]      bank_rdata_i,
  output logic [NUM_BANKS-1:0]                 bank_pwr_o,
  output logic [NUM_BANKS-1:0]                 bank_on_o
);

  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int BADDR_W = ADDR_WIDTH - BANK_W;
  localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);
  localparam int WAKE_W  = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } pwr_state_e;

  logic [BANK_W-1:0]     w_sel;
  logic [NUM_BANKS-1:0]  w_hit;
  logic [NUM_BANKS-1:0]  w_on;
  logic                  w_gnt;
  logic [DATA_WIDTH-1:0] w_slice [NUM_BANKS];

  logic                  r_rvalid;
  logic                  r_rd;
  logic [BANK_W-1:0]     r_sel;

  assign w_sel = addr_i[ADDR_WIDTH-1 -: BANK_W];
  assign w_hit = NUM_BANKS'(req_i) << w_sel;
  assign w_gnt = req_i & w_on[w_sel];

  assign gnt_o        = w_gnt;
  assign bank_en_o    = NUM_BANKS'(w_gnt) << w_sel;
  assign bank_addr_o  = addr_i[BADDR_W-1:0];
  assign bank_we_o    = we_i;
  assign bank_be_o    = be_i;
  assign bank_wdata_o = wdata_i;
  assign bank_on_o    = w_on;

  // Response is one cycle behind the grant; remember which bank and whether it was a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rd     <= 1'b0;
      r_sel    <= '0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt) begin
        r_rd  <= ~we_i;
        r_sel <= w_sel;
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = (r_rvalid && r_rd) ? w_slice[r_sel] : '0;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    pwr_state_e        r_state;
    logic [IDLE_W-1:0] r_idle;
    logic [WAKE_W-1:0] r_wake;
    logic              r_pwr;
    logic              r_on;

    assign w_slice[b]    = bank_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
    assign w_on[b]       = r_on;
    assign bank_pwr_o[b] = r_pwr;

    // Idle count saturates, so a bank held awake by testmode sleeps as soon as it is released.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_ON;
        r_idle  <= '0;
        r_wake  <= '0;
        r_pwr   <= 1'b1;
        r_on    <= 1'b1;
      end else begin
        case (r_state)
          ST_ON: begin
            if (w_hit[b]) begin
              r_idle <= '0;
            end else if (sleep_en_i[b] && !testmode_i &&
                         r_idle >= IDLE_W'(IDLE_CYCLES - 1)) begin
              r_state <= ST_SLEEP;
              r_pwr   <= 1'b0;
              r_on    <= 1'b0;
              r_idle  <= '0;
            end else if (r_idle != IDLE_W'(IDLE_CYCLES)) begin
              r_idle <= r_idle + 1'b1;
            end
          end
          ST_SLEEP: begin
            if (w_hit[b] || !sleep_en_i[b] || testmode_i) begin
              r_state <= ST_WAKE;
              r_pwr   <= 1'b1;
              r_wake  <= '0;
            end
          end
          ST_WAKE: begin
            if (r_wake == WAKE_W'(WAKE_CYCLES - 1)) begin
              r_state <= ST_ON;
              r_on    <= 1'b1;
              r_idle  <= '0;
              r_wake  <= '0;
            end else begin
              r_wake <= r_wake + 1'b1;
            end
          end
          default: begin
            r_state <= ST_ON;
            r_pwr   <= 1'b1;
            r_on    <= 1'b1;
            r_idle  <= '0;
            r_wake  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulpino_mem_banked.sv
// Directed bench for pulpino_mem_banked: access timing, idle sleep, wake stall,
// testmode override and asynchronous reset, with hand-computed expectations.
module tb_pulpino_mem_banked;

  logic         clk;
  logic         rst_n;
  logic         testmode_i;
  logic [3:0]   sleep_en_i;
  logic         req_i;
  logic [12:0]  addr_i;
  logic         we_i;
  logic [3:0]   be_i;
  logic [31:0]  wdata_i;
  logic         gnt_o;
  logic         rvalid_o;
  logic [31:0]  rdata_o;
  logic [3:0]   bank_en_o;
  logic [10:0]  bank_addr_o;
  logic         bank_we_o;
  logic [3:0]   bank_be_o;
  logic [31:0]  bank_wdata_o;
  logic [127:0] bank_rdata_i;
  logic [3:0]   bank_pwr_o;
  logic [3:0]   bank_on_o;

  int n_vec = 0;
  int n_err = 0;

  pulpino_mem_banked dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .testmode_i   (testmode_i),
    .sleep_en_i   (sleep_en_i),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .bank_en_o    (bank_en_o),
    .bank_addr_o  (bank_addr_o),
    .bank_we_o    (bank_we_o),
    .bank_be_o    (bank_be_o),
    .bank_wdata_o (bank_wdata_o),
    .bank_rdata_i (bank_rdata_i),
    .bank_pwr_o   (bank_pwr_o),
    .bank_on_o    (bank_on_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("vector %s differs", tag);
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rq, input logic [12:0] a, input logic w,
                       input logic [3:0] be, input logic [31:0] wd);
    req_i   = rq;
    addr_i  = a;
    we_i    = w;
    be_i    = be;
    wdata_i = wd;
  endtask

  // Reset is released on a falling edge; the following rising edge ends cycle 0.
  task automatic do_reset(input logic [3:0] sen);
    drive(1'b0, 13'h0, 1'b0, 4'h0, 32'h0);
    testmode_i = 1'b0;
    sleep_en_i = sen;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b1;
    testmode_i   = 1'b0;
    sleep_en_i   = 4'b0000;
    bank_rdata_i = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    drive(1'b0, 13'h0, 1'b0, 4'h0, 32'h0);

    // Reset values
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt_o, 1'b0);
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_bank_en", bank_en_o, 4'b0000);
    chk("rst_bank_we", bank_we_o, 1'b0);
    chk("rst_pwr", bank_pwr_o, 4'b1111);
    chk("rst_on", bank_on_o, 4'b1111);
    do_reset(4'b0000);

    // Read bank 2
    next_cycle();
    drive(1'b1, 13'h1005, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("rd2_gnt", gnt_o, 1'b1);
    chk("rd2_bank_en", bank_en_o, 4'b0100);
    chk("rd2_bank_addr", bank_addr_o, 11'h005);
    chk("rd2_rvalid_early", rvalid_o, 1'b0);
    next_cycle();
    drive(1'b0, 13'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd2_rvalid", rvalid_o, 1'b1);
    chk("rd2_rdata", rdata_o, 32'hA5A5_0002);
    chk("rd2_idle_en", bank_en_o, 4'b0000);
    next_cycle();
    @(negedge clk);
    chk("rd2_rvalid_drop", rvalid_o, 1'b0);
    chk("rd2_rdata_zero", rdata_o, 32'h0);

    // Write bank 1, then back-to-back read of bank 3
    next_cycle();
    drive(1'b1, 13'h0810, 1'b1, 4'b0011, 32'h1234_5678);
    @(negedge clk);
    chk("wr1_gnt", gnt_o, 1'b1);
    chk("wr1_bank_en", bank_en_o, 4'b0010);
    chk("wr1_bank_we", bank_we_o, 1'b1);
    chk("wr1_bank_be", bank_be_o, 4'b0011);
    chk("wr1_bank_wdata", bank_wdata_o, 32'h1234_5678);
    chk("wr1_bank_addr", bank_addr_o, 11'h010);
    next_cycle();
    drive(1'b1, 13'h1820, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("b2b_gnt", gnt_o, 1'b1);
    chk("b2b_bank_en", bank_en_o, 4'b1000);
    chk("wr1_rvalid", rvalid_o, 1'b1);
    chk("wr1_rdata", rdata_o, 32'h0);
    next_cycle();
    drive(1'b0, 13'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b_rvalid", rvalid_o, 1'b1);
    chk("b2b_rdata", rdata_o, 32'hA5A5_0003);

    // Idle sleep: with no traffic after reset, cycle 63 is the expiry cycle
    do_reset(4'b1111);
    wait_cycles(63);
    @(negedge clk);
    chk("idle63_pwr", bank_pwr_o, 4'b1111);
    next_cycle();
    @(negedge clk);
    chk("idle64_pwr", bank_pwr_o, 4'b0000);
    chk("idle64_on", bank_on_o, 4'b0000);

    // Wake on demand: request at t, grant at t+5
    next_cycle();
    drive(1'b1, 13'h1820, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("wake_t_gnt", gnt_o, 1'b0);
    chk("wake_t_pwr", bank_pwr_o, 4'b0000);
    next_cycle();
    @(negedge clk);
    chk("wake_t1_gnt", gnt_o, 1'b0);
    chk("wake_t1_pwr", bank_pwr_o, 4'b1000);
    chk("wake_t1_on", bank_on_o, 4'b0000);
    wait_cycles(3);
    @(negedge clk);
    chk("wake_t4_gnt", gnt_o, 1'b0);
    chk("wake_t4_on", bank_on_o, 4'b0000);
    next_cycle();
    @(negedge clk);
    chk("wake_t5_gnt", gnt_o, 1'b1);
    chk("wake_t5_on", bank_on_o, 4'b1000);
    chk("wake_t5_bank_en", bank_en_o, 4'b1000);
    next_cycle();
    drive(1'b0, 13'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk("wake_t6_rvalid", rvalid_o, 1'b1);
    chk("wake_t6_rdata", rdata_o, 32'hA5A5_0003);

    // Testmode wakes sleeping banks and keeps all banks on
    next_cycle();
    testmode_i = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("tm_u1_pwr", bank_pwr_o, 4'b1111);
    chk("tm_u1_on", bank_on_o, 4'b1000);
    wait_cycles(3);
    @(negedge clk);
    chk("tm_u4_on", bank_on_o, 4'b1000);
    next_cycle();
    @(negedge clk);
    chk("tm_u5_on", bank_on_o, 4'b1111);
    wait_cycles(100);
    @(negedge clk);
    chk("tm_hold_pwr", bank_pwr_o, 4'b1111);
    chk("tm_hold_on", bank_on_o, 4'b1111);

    // Request in the exact expiry cycle; only bank 0 may sleep
    do_reset(4'b0001);
    wait_cycles(63);
    drive(1'b1, 13'h0003, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("exp_gnt", gnt_o, 1'b1);
    chk("exp_bank_en", bank_en_o, 4'b0001);
    next_cycle();
    drive(1'b0, 13'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk("exp_pwr", bank_pwr_o, 4'b1111);
    chk("exp_rvalid", rvalid_o, 1'b1);
    chk("exp_rdata", rdata_o, 32'hA5A5_0000);
    wait_cycles(63);
    @(negedge clk);
    chk("sen1_127_pwr", bank_pwr_o, 4'b1111);
    next_cycle();
    @(negedge clk);
    chk("sen1_128_pwr", bank_pwr_o, 4'b1110);
    chk("sen1_128_on", bank_on_o, 4'b1110);

    // Reset during a wake with a response pending
    next_cycle();
    sleep_en_i = 4'b0000;
    next_cycle();
    drive(1'b1, 13'h0810, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("arst_pre_gnt", gnt_o, 1'b1);
    chk("arst_pre_on", bank_on_o, 4'b1110);
    chk("arst_pre_pwr", bank_pwr_o, 4'b1111);
    #1;
    drive(1'b0, 13'h0, 1'b0, 4'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("arst_on", bank_on_o, 4'b1111);
    chk("arst_pwr", bank_pwr_o, 4'b1111);
    chk("arst_rvalid", rvalid_o, 1'b0);
    chk("arst_gnt", gnt_o, 1'b0);
    @(posedge clk);
    #1;
    chk("arst_edge_rvalid", rvalid_o, 1'b0);
    chk("arst_edge_rdata", rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("arst_post_rvalid", rvalid_o, 1'b0);
    chk("arst_post_on", bank_on_o, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
